// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision serial adder.
//   WORD_W  : width of one adder word
//   state_t : sequencer states (IDLE, RUN, DONE)
package mp_add_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addition64.sv
// Combinational 64-bit adder with carry in and carry out.
// Ports:
//   a, b      : 64-bit addends
//   carry_in  : carry into bit 0
//   sum       : 64-bit result
//   carry_out : carry out of bit 63
module addition64
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              carry_in,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, carry_in};

endmodule

// File: rtl/mp_add_serial.sv
// Multi-precision serial adder/subtractor.
// Latches two WORDS*64-bit operands and pushes them through one addition64,
// one word per cycle starting with the least significant word, chaining the
// carry through a register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while ready=1
//   sub        : 0 add, 1 subtract (sampled with start)
//   a, b       : N-bit operands (sampled with start)
//   carry_in   : carry-in / borrow-in (sampled with start)
//   ready      : idle, a start will be accepted
//   done       : one-cycle pulse, sum/carry_out valid
//   sum        : N-bit result, held until the next accepted start
//   carry_out  : carry-out / borrow-out
//   dbg_state  : current sequencer state
//
// Handshake: a request transfers on a rising edge where start=1 and ready=1;
// start while ready=0 is ignored. The result is signalled by done=1 for one
// cycle, WORDS+1 cycles after the accepting edge; there is no back-pressure.
module mp_add_serial
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4,
  localparam int N = WORD_W * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output state_t       dbg_state
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          carry_q, carry_d;
  logic                          sub_q, sub_d;
  logic [WORDS-1:0][WORD_W-1:0]  a_q, a_d;
  logic [WORDS-1:0][WORD_W-1:0]  b_q, b_d;
  logic [WORDS-1:0][WORD_W-1:0]  sum_q, sum_d;

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_sum;
  logic              add_co;

  // Subtraction is a + ~b + ~borrow_in: the carry register is seeded with
  // carry_in ^ sub, and the final carry is flipped back into a borrow.
  assign add_a = a_q[idx_q];
  assign add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];

  addition64 u_add (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (carry_q),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = carry_in ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_co;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // carry_q and sub_q are frozen from DONE until the next accepted start,
  // so this stays stable over the whole result-valid window.
  assign carry_out = carry_q ^ sub_q;
  assign sum       = sum_q;
  assign dbg_state = state_q;

endmodule
